// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding, per-boundary widths and control-field bit positions
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    // Default field widths per stage boundary
    localparam int IFID_CTRL_W  = 1;
    localparam int IFID_DATA_W  = 64;
    localparam int IDEX_CTRL_W  = 12;
    localparam int IDEX_DATA_W  = 133;
    localparam int EXMEM_CTRL_W = 5;
    localparam int EXMEM_DATA_W = 101;
    localparam int MEMWB_CTRL_W = 3;
    localparam int MEMWB_DATA_W = 101;

    // EX/MEM-style control field layout
    localparam int CTRL_REGWRITE    = 0;
    localparam int CTRL_MEMTOREG_LO = 1;
    localparam int CTRL_MEMTOREG_HI = 2;
    localparam int CTRL_MEMREAD     = 3;
    localparam int CTRL_MEMWRITE    = 4;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid+ctrl+data holding register with load and clear-ctrl enables
module pipe_slot #(
    parameter int CTRL_W = 5,
    parameter int DATA_W = 101
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clr,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Clear wins over load; data is kept on clear since it is don't-care once invalid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline register with 2-entry skid and flush; PIPE_STAGE_STATS_EN adds stall/bubble counters
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EXMEM_CTRL_W,
    parameter int DATA_W = EXMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
`ifdef PIPE_STAGE_STATS_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt,
`endif
    output logic [DATA_W-1:0] out_data
);

    pipe_state_e       r_state;
    pipe_state_e       w_state_nxt;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_main_load;
    logic              w_main_from_skid;
    logic              w_main_clr;
    logic              w_skid_load;
    logic              w_skid_clr;
    logic [CTRL_W-1:0] w_main_ctrl_d;
    logic [DATA_W-1:0] w_main_data_d;
    logic              w_main_valid;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;

    // Readiness depends on registered state only, never on out_ready
    assign in_ready   = (r_state != ST_FULL);
    assign out_valid  = (r_state != ST_EMPTY);
    assign out_ctrl   = w_main_ctrl & {CTRL_W{out_valid}};
    assign out_data   = w_main_data;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_main_clr       = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clr       = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_clr  = 1'b1;
            w_skid_clr  = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ST_ONE;
                        w_main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    case ({w_in_fire, w_out_fire})
                        2'b11: w_main_load = 1'b1;
                        2'b10: begin
                            w_state_nxt = ST_FULL;
                            w_skid_load = 1'b1;
                        end
                        2'b01: begin
                            w_state_nxt = ST_EMPTY;
                            w_main_clr  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt      = ST_ONE;
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clr       = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    assign w_main_ctrl_d = w_main_from_skid ? w_skid_ctrl : in_ctrl;
    assign w_main_data_d = w_main_from_skid ? w_skid_data : in_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_main_load),
        .i_clr   (w_main_clr),
        .i_ctrl  (w_main_ctrl_d),
        .i_data  (w_main_data_d),
        .o_valid (w_main_valid),
        .o_ctrl  (w_main_ctrl),
        .o_data  (w_main_data)
    );

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clr   (w_skid_clr),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
    );

    // Slot valid bits must always agree with the state encoding
    a_slot_state: assert property (@(posedge clk) disable iff (!rst)
        (w_main_valid == (r_state != ST_EMPTY)) && (w_skid_valid == (r_state == ST_FULL)));

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (!out_valid && out_ready) r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - directed self-checking bench for pipe_stage_elastic
module tb_pipe_stage_elastic;

    localparam int CW = 5;
    localparam int DW = 101;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   bubble_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
`ifdef PIPE_STAGE_STATS_EN
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
`endif
        .out_data   (out_data)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 5'h1F, 101'h1234);
        step(); step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ctrl",  out_ctrl, 0);
        check("rst_out_data",  out_data, 0);
        check("rst_in_ready",  in_ready, 1);
        rst = 1'b1;
        step();
        check("first_out_valid", out_valid, 1);
        check("first_out_ctrl",  out_ctrl, 5'h1F);
        check("first_out_data",  out_data, 101'h1234);
        drive(1'b0, 5'h00, '0);
        out_ready = 1'b1;
        step();
        check("drain_out_valid", out_valid, 0);
        check("drain_out_ctrl",  out_ctrl, 0);

        // Streaming 1..8 at one per cycle
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, CW'(i), DW'(i));
            step();
            check($sformatf("stream_data_%0d", i), out_data, i);
            check($sformatf("stream_ctrl_%0d", i), out_ctrl, i);
            check($sformatf("stream_ready_%0d", i), in_ready, 1);
        end
        drive(1'b0, 5'h00, '0);
        step();
        check("stream_end_valid", out_valid, 0);

        // Back-pressure: A then B held, extra X refused
        out_ready = 1'b0;
        drive(1'b1, 5'h03, 101'hA);
        step();
        check("bp_a_data", out_data, 101'hA);
        check("bp_a_ready", in_ready, 1);
        drive(1'b1, 5'h05, 101'hB);
        step();
        check("bp_full_ready", in_ready, 0);
        check("bp_full_data", out_data, 101'hA);
        drive(1'b1, 5'h07, 101'hEE);
        step();
        check("bp_hold_data", out_data, 101'hA);
        check("bp_hold_ctrl", out_ctrl, 5'h03);
        drive(1'b0, 5'h00, '0);
        out_ready = 1'b1;
        step();
        check("bp_b_data", out_data, 101'hB);
        check("bp_b_ctrl", out_ctrl, 5'h05);
        check("bp_b_ready", in_ready, 1);
        step();
        check("bp_empty_valid", out_valid, 0);

        // Flush while FULL with a concurrent push of C
        out_ready = 1'b0;
        drive(1'b1, 5'h11, 101'hA1);
        step();
        drive(1'b1, 5'h12, 101'hB2);
        step();
        check("fl_pre_ready", in_ready, 0);
        flush = 1'b1;
        drive(1'b1, 5'h13, 101'hC3);
        step();
        flush = 1'b0;
        drive(1'b0, 5'h00, '0);
        check("fl_out_valid", out_valid, 0);
        check("fl_out_ctrl", out_ctrl, 0);
        check("fl_in_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        check("fl_post_valid", out_valid, 0);

        // Flush while EMPTY swallows the incoming push
        flush = 1'b1;
        drive(1'b1, 5'h1E, 101'hC4);
        step();
        flush = 1'b0;
        drive(1'b0, 5'h00, '0);
        check("fl_in_fire_dropped", out_valid, 0);

        // Simultaneous in_fire and out_fire in ONE
        drive(1'b1, 5'h09, 101'hD);
        step();
        check("sim_d_data", out_data, 101'hD);
        drive(1'b1, 5'h0A, 101'hE);
        step();
        check("sim_e_data", out_data, 101'hE);
        check("sim_e_ctrl", out_ctrl, 5'h0A);
        check("sim_e_ready", in_ready, 1);
        drive(1'b0, 5'h00, '0);
        step();
        check("sim_end_valid", out_valid, 0);

        // Wide data word survives the skid path intact
        out_ready = 1'b0;
        drive(1'b1, 5'h01, {1'b1, 100'h0});
        step();
        drive(1'b1, 5'h02, {1'b1, {100{1'b1}}});
        step();
        drive(1'b0, 5'h00, '0);
        out_ready = 1'b1;
        step();
        check("wide_skid_data", out_data, {27'h0, 1'b1, {100{1'b1}}});
        step();

`ifdef PIPE_STAGE_STATS_EN
        rst = 1'b0; out_ready = 1'b0;
        step();
        check("st_rst_stall", stall_cnt, 0);
        check("st_rst_bubble", bubble_cnt, 0);
        rst = 1'b1;
        drive(1'b1, 5'h04, 101'h44);
        step();
        drive(1'b0, 5'h00, '0);
        step(); step(); step();
        check("st_stall3", stall_cnt, 3);
        out_ready = 1'b1;
        step();
        step(); step();
        check("st_stall_final", stall_cnt, 3);
        check("st_bubble2", bubble_cnt, 2);
        out_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("st_flush_stall", stall_cnt, 3);
        check("st_flush_bubble", bubble_cnt, 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
